// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back L2 line cache with tree PLRU; `define L2_PERF_CTR_EN adds saturating hit/miss counters.
// Latency: a hit answers 2 cycles after the request is first seen; a miss adds an optional writeback plus a fill.
// Backpressure: requests are taken only in IDLE and held until mem_resp; pmem requests are held until pmem_resp.
module l2_cache_nway #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata256,
    input  logic [31:0]  mem_byte_enable256,
    output logic [255:0] mem_rdata256,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);
    localparam int SETS = 2 ** S_INDEX;
    localparam int TW   = 32 - S_OFFSET - S_INDEX;
    localparam int WB   = $clog2(NUM_WAYS);

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

    state_t               state;
    logic                 req_write;
    logic [31-S_OFFSET:0] req_line;
    logic [255:0]         req_wdata;
    logic [31:0]          req_be;
    logic [WB-1:0]        victim_q;

    logic [TW-1:0]       tag_arr   [NUM_WAYS][SETS];
    logic [255:0]        data_arr  [NUM_WAYS][SETS];
    logic [NUM_WAYS-1:0] valid_arr [SETS];
    logic [NUM_WAYS-1:0] dirty_arr [SETS];
    logic [NUM_WAYS-2:0] plru_arr  [SETS];

    logic [S_INDEX-1:0] idx;
    logic [TW-1:0]      req_tag;
    logic               hit;
    logic [WB-1:0]      hit_way;
    logic               inv_found;
    logic [WB-1:0]      inv_way;
    logic [WB-1:0]      victim_way;
    logic [255:0]       merged_line;
    logic               unused_addr_bits;

    assign idx              = req_line[S_INDEX-1:0];
    assign req_tag          = req_line[31-S_OFFSET -: TW];
    assign unused_addr_bits = ^mem_address[S_OFFSET-1:0];

    // Tree walk: node n has children 2n and 2n+1; a 0 bit points at the lower half.
    function automatic logic [WB-1:0] plru_pick(input logic [NUM_WAYS-2:0] bits);
        logic [NUM_WAYS-1:0] t;
        logic [WB:0]         node;
        t    = {bits, 1'b0};
        node = (WB+1)'(1);
        for (int l = 0; l < WB; l++) begin
            node = {node[WB-1:0], t[node[WB-1:0]]};
        end
        return node[WB-1:0];
    endfunction

    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                       input logic [WB-1:0] way);
        logic [NUM_WAYS-1:0] t;
        logic [WB:0]         node;
        logic                dir;
        t    = {bits, 1'b0};
        node = (WB+1)'(1);
        for (int l = 0; l < WB; l++) begin
            dir                 = way[WB-1-l];
            t[node[WB-1:0]]     = ~dir;
            node                = {node[WB-1:0], dir};
        end
        return t[NUM_WAYS-1:1];
    endfunction

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = NUM_WAYS-1; w >= 0; w--) begin
            if (valid_arr[idx][w] && tag_arr[w][idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
            if (!valid_arr[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WB'(w);
            end
        end
        victim_way = inv_found ? inv_way : plru_pick(plru_arr[idx]);
    end

    always_comb begin
        merged_line = data_arr[hit_way][idx];
        for (int b = 0; b < 32; b++) begin
            if (req_be[b]) merged_line[8*b +: 8] = req_wdata[8*b +: 8];
        end
    end

    assign mem_rdata256 = data_arr[hit_way][idx];
    assign mem_resp     = (state == COMPARE) && hit;
    assign pmem_read    = (state == FILL);
    assign pmem_write   = (state == WRITEBACK);
    assign pmem_wdata   = data_arr[victim_q][idx];
    assign pmem_address = (state == WRITEBACK) ?
                          {tag_arr[victim_q][idx], idx, {S_OFFSET{1'b0}}} :
                          {req_line, {S_OFFSET{1'b0}}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_write <= 1'b0;
            req_line  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            victim_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        req_write <= mem_write;
                        req_line  <= mem_address[31:S_OFFSET];
                        req_wdata <= mem_wdata256;
                        req_be    <= mem_byte_enable256;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        plru_arr[idx] <= plru_touch(plru_arr[idx], hit_way);
                        if (req_write && (req_be != '0)) dirty_arr[idx][hit_way] <= 1'b1;
                        state <= IDLE;
                    end else begin
                        victim_q <= victim_way;
                        state    <= (valid_arr[idx][victim_way] && dirty_arr[idx][victim_way]) ?
                                    WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) state <= FILL;
                end
                FILL: begin
                    if (pmem_resp) begin
                        valid_arr[idx][victim_q] <= 1'b1;
                        dirty_arr[idx][victim_q] <= 1'b0;
                        state                    <= COMPARE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (state == COMPARE && hit && req_write) begin
            data_arr[hit_way][idx] <= merged_line;
        end
        if (state == FILL && pmem_resp) begin
            data_arr[victim_q][idx] <= pmem_rdata;
            tag_arr[victim_q][idx]  <= req_tag;
        end
    end

`ifdef L2_PERF_CTR_EN
    logic miss_seen;

    // The hit that completes a refilled request is not a real hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_seen  <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && (mem_read || mem_write)) miss_seen <= 1'b0;
            if (state == COMPARE) begin
                if (hit) begin
                    if (!miss_seen && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
                end else begin
                    miss_seen <= 1'b1;
                    if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
                end
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l2_cache_nway.sv
// Directed bench for l2_cache_nway: behavioural pmem answering 4 cycles after a request, hand-derived expectations.
module tb_l2_cache_nway;
`ifdef L2_PERF_CTR_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0]  mem_address = '0;
    logic [255:0] mem_wdata256 = '0;
    logic [31:0]  mem_byte_enable256 = '0;
    logic [255:0] mem_rdata256;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic [31:0]  hit_count, miss_count;

    always #5 clk = ~clk;

    l2_cache_nway dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata256(mem_wdata256), .mem_byte_enable256(mem_byte_enable256),
        .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int n_vec = 0;
    int n_bad = 0;
    int excl_viol = 0;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = a ^ (32'(i) * 32'h0101_0101);
        return l;
    endfunction

    logic [255:0] pmem_store [logic [31:0]];
    logic         log_w [$];
    logic [31:0]  log_a [$];
    logic [255:0] log_d [$];

    function automatic logic [255:0] pmem_line(input logic [31:0] a);
        if (pmem_store.exists(a)) return pmem_store[a];
        return line_of(a);
    endfunction

    function automatic logic [31:0] la(input int i);
        return (i < log_a.size()) ? log_a[i] : 32'hFFFF_FFFF;
    endfunction
    function automatic logic lw(input int i);
        return (i < log_w.size()) ? log_w[i] : 1'bx;
    endfunction
    function automatic logic [255:0] ld(input int i);
        return (i < log_d.size()) ? log_d[i] : '1;
    endfunction

    // Behavioural downstream memory: one-cycle pmem_resp 4 cycles after a request is seen.
    initial begin
        logic         is_w;
        logic [31:0]  a;
        logic [255:0] wd;
        forever begin
            @(negedge clk);
            if (rst && (pmem_read || pmem_write)) begin
                is_w = pmem_write;
                a    = pmem_address;
                wd   = pmem_wdata;
                log_w.push_back(is_w);
                log_a.push_back(a);
                log_d.push_back(wd);
                repeat (3) @(negedge clk);
                if (rst && (pmem_read || pmem_write)) begin
                    if (is_w) pmem_store[a] = wd;
                    else pmem_rdata = pmem_line(a);
                    pmem_resp = 1'b1;
                    @(negedge clk);
                    pmem_resp = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) if (pmem_read && pmem_write) excl_viol++;

    int           last_cyc;
    logic [255:0] last_rdata;

    // Cycle 1 is the cycle whose rising edge first samples the request.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [255:0] wd, input logic [31:0] be);
        logic got;
        log_w.delete(); log_a.delete(); log_d.delete();
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_address = addr;
        mem_wdata256 = wd; mem_byte_enable256 = be;
        last_cyc = 1;
        got = 1'b0;
        while (!got && last_cyc < 300) begin
            @(posedge clk); #1;
            last_cyc++;
            if (mem_resp) begin
                got = 1'b1;
                last_rdata = mem_rdata256;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        check($sformatf("resp_%h", addr), got, 1'b1);
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_resp", mem_resp, 1'b0);
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1);
    end

    initial begin
        logic [255:0] wd, exp_line;
        int n;
        #3 rst = 1'b0;
        #20 rst = 1'b1;
        do_reset();

        // Read miss then hits, then write miss: counter sequence and basic fill.
        do_req(1, 0, 32'h0000_1040, '0, '0);
        check("s1_log_n", 32'(log_a.size()), 32'd1);
        check("s1_fill_addr", la(0), 32'h0000_1040);
        check("s1_fill_kind", lw(0), 1'b0);
        check("s1_miss_data", last_rdata, line_of(32'h0000_1040));
        do_req(1, 0, 32'h0000_1040, '0, '0);
        check("s1_hit_lat", 32'(last_cyc), 32'd2);
        check("s1_hit_nopmem", 32'(log_a.size()), 32'd0);
        check("s1_hit_data", last_rdata, line_of(32'h0000_1040));
        do_req(1, 0, 32'h0000_1040, '0, '0);
        check("s5_hit2_lat", 32'(last_cyc), 32'd2);
        do_req(0, 1, 32'h0000_5040, {224'h0, 32'hDEAD_BEEF}, 32'h0000_000F);
        check("s5_wmiss_addr", la(0), 32'h0000_5040);
        check("s5_hit_count", hit_count, PERF ? 32'd2 : 32'd0);
        check("s5_miss_count", miss_count, PERF ? 32'd2 : 32'd0);

        // Partial write hit merges only the enabled low word.
        wd = {28{8'h11}};
        wd = {wd[223:0], 32'hDEAD_BEEF};
        do_req(0, 1, 32'h0000_1040, wd, 32'h0000_000F);
        check("s2_whit_lat", 32'(last_cyc), 32'd2);
        check("s2_whit_nopmem", 32'(log_a.size()), 32'd0);
        do_req(1, 0, 32'h0000_1040, '0, '0);
        exp_line = line_of(32'h0000_1040);
        exp_line[31:0] = 32'hDEAD_BEEF;
        check("s2_merged", last_rdata, exp_line);
        check("s2_hit_count", hit_count, PERF ? 32'd4 : 32'd0);

        // Fill set 2 with tags 0..7, tag 0 dirty and least recent, then force an eviction.
        do_reset();
        do_req(0, 1, 32'h0000_0040, {192'h0, 32'hCAFE_F00D, 32'h0}, 32'h0000_00F0);
        check("s3_t0_fill", la(0), 32'h0000_0040);
        for (int k = 1; k < 8; k++) begin
            do_req(1, 0, 32'h0000_0040 + 32'(k) * 32'h100, '0, '0);
            check($sformatf("s3_t%0d_fill", k), la(0), 32'h0000_0040 + 32'(k) * 32'h100);
        end
        exp_line = line_of(32'h0000_0040);
        exp_line[63:32] = 32'hCAFE_F00D;
        do_req(1, 0, 32'h0000_0840, '0, '0);
        check("s3_evict_log_n", 32'(log_a.size()), 32'd2);
        check("s3_wb_kind", lw(0), 1'b1);
        check("s3_wb_addr", la(0), 32'h0000_0040);
        check("s3_wb_data", ld(0), exp_line);
        check("s3_refill_kind", lw(1), 1'b0);
        check("s3_refill_addr", la(1), 32'h0000_0840);
        check("s3_new_data", last_rdata, line_of(32'h0000_0840));
        do_req(1, 0, 32'h0000_0140, '0, '0);
        check("s3_t1_still_hit", 32'(last_cyc), 32'd2);
        // Next victim is clean way 4, so tag 0 comes back with no writeback.
        do_req(1, 0, 32'h0000_0040, '0, '0);
        check("s3_reload_log_n", 32'(log_a.size()), 32'd1);
        check("s3_reload_kind", lw(0), 1'b0);
        check("s3_reload_data", last_rdata, exp_line);

        // Read+write with no byte enables: a write that leaves the line clean.
        do_req(1, 1, 32'h0000_2000, '1, 32'h0000_0000);
        check("s6_fill_addr", la(0), 32'h0000_2000);
        do_req(1, 0, 32'h0000_2000, '0, '0);
        check("s6_unchanged", last_rdata, line_of(32'h0000_2000));
        for (int k = 1; k < 8; k++) do_req(1, 0, 32'h0000_2000 + 32'(k) * 32'h100, '0, '0);
        do_req(1, 0, 32'h0000_2800, '0, '0);
        check("s6_clean_evict_n", 32'(log_a.size()), 32'd1);
        check("s6_clean_evict_kind", lw(0), 1'b0);

        // Reset in the middle of a fill.
        do_reset();
        @(negedge clk);
        mem_read = 1'b1; mem_address = 32'h0000_3000;
        n = 0;
        while (!pmem_read && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("s4_fill_seen", pmem_read, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("s4_pmem_read_drop", pmem_read, 1'b0);
        check("s4_no_resp", mem_resp, 1'b0);
        mem_read = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        do_req(1, 0, 32'h0000_3000, '0, '0);
        check("s4_remiss_n", 32'(log_a.size()), 32'd1);
        check("s4_remiss_addr", la(0), 32'h0000_3000);
        check("s4_remiss_data", last_rdata, line_of(32'h0000_3000));

        check("pmem_exclusive", 32'(excl_viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/l2_cache_nway.md
L2_CACHE_NWAY -- requirements
Module: l2_cache_nway

Interface
REQ-001 The module SHALL have parameter S_OFFSET, default 5, meaning byte-offset bits; the line is 2**S_OFFSET bytes, fixed at 256 bits.
REQ-002 The module SHALL have parameter S_INDEX, default 3, meaning set-index bits; there are 2**S_INDEX sets.
REQ-003 The module SHALL have parameter NUM_WAYS, default 8, meaning associativity; legal values are powers of two from 2 to 16. Tag width is 32-S_OFFSET-S_INDEX.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have ports mem_read and mem_write, inputs, 1 bit each: upstream request strobes, held stable until mem_resp.
REQ-007 The module SHALL have port mem_address, input, 32 bits: upstream byte address.
REQ-008 The module SHALL have ports mem_wdata256 (input, 256 bits) and mem_byte_enable256 (input, 32 bits): upstream write line and byte mask.
REQ-009 The module SHALL have ports mem_rdata256 (output, 256 bits) and mem_resp (output, 1 bit): upstream read line and one-cycle completion pulse.
REQ-010 The module SHALL have ports pmem_read and pmem_write (outputs, 1 bit each), pmem_address (output, 32 bits) and pmem_wdata (output, 256 bits): downstream request.
REQ-011 The module SHALL have ports pmem_rdata (input, 256 bits) and pmem_resp (input, 1 bit): downstream return and completion pulse.
REQ-012 The module SHALL have ports hit_count and miss_count, outputs, 32 bits each: performance counters (see Configuration).

Function
REQ-013 Each way SHALL hold per-set tag, valid, dirty and a 256-bit data line; reads are combinational on the index, writes are synchronous.
REQ-014 Each set SHALL hold a NUM_WAYS-1-bit tree pseudo-LRU (PLRU); on every hit the PLRU SHALL be updated so that it points away from the accessed way.
REQ-015 The FSM SHALL have states IDLE, COMPARE, WRITEBACK and FILL.
REQ-016 IDLE SHALL move to COMPARE on the cycle after mem_read or mem_write is seen high. If both are high, the request SHALL be treated as a write.
REQ-017 In COMPARE on a hit, mem_resp SHALL be high for exactly one cycle and the FSM SHALL return to IDLE.
  - On a read hit, mem_rdata256 SHALL equal the hit line in that cycle.
  - On a write hit, the enabled bytes SHALL be merged into the line, and dirty SHALL be set only if mem_byte_enable256 is nonzero.
REQ-018 Hit latency SHALL be 2 cycles from the first request cycle to mem_resp.
REQ-019 In COMPARE on a miss, the victim SHALL be the lowest-index invalid way, otherwise the PLRU way. The FSM SHALL go to WRITEBACK if the victim is valid and dirty, else to FILL.
REQ-020 In WRITEBACK, the module SHALL hold pmem_write=1, pmem_address={victim tag, index, S_OFFSET zeros} and pmem_wdata=victim line until pmem_resp, then go to FILL.
REQ-021 In FILL, the module SHALL hold pmem_read=1 and pmem_address={mem_address[31:S_OFFSET], zeros} until pmem_resp. On pmem_resp it SHALL write pmem_rdata, the tag, valid=1 and dirty=0 into the victim, then return to COMPARE, which then hits.
REQ-022 pmem_read and pmem_write SHALL never be high together; pmem_resp outside WRITEBACK/FILL SHALL be ignored.
REQ-023 The victim way SHALL be latched on leaving COMPARE and held constant through WRITEBACK and FILL.
REQ-024 Request inputs SHALL be ignored in all states other than IDLE. Back-to-back requests SHALL therefore be spaced by at least one IDLE cycle.

Reset
REQ-025 While rst=0, the module SHALL immediately (asynchronously) force state=IDLE and clear all valid, dirty and PLRU bits.
REQ-026 While rst=0, mem_resp, pmem_read, pmem_write, hit_count and miss_count SHALL be 0; tag and data arrays are not reset.
REQ-027 Reset asserted mid-WRITEBACK or mid-FILL SHALL deassert pmem_read/pmem_write combinationally and abandon the transaction.

Configuration
REQ-028 When L2_PERF_CTR_EN is defined, miss_count SHALL increment on each COMPARE miss, and hit_count SHALL increment on a COMPARE hit only if no miss occurred for the current request. Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-029 When L2_PERF_CTR_EN is undefined, hit_count and miss_count SHALL be constant 0 and no counter flops SHALL exist.

Verification (NUM_WAYS=8, S_INDEX=3, one-cycle pmem_resp after 4 cycles)
REQ-030 Scenario 1: after reset, read 0x0000_1040 -> pmem_read at 0x0000_1040, no pmem_write, mem_resp with pmem_rdata line; repeat read -> mem_resp 2 cycles after request, no pmem activity.
REQ-031 Scenario 2: write 0x0000_1040 with byte_enable 0x0000_000F, data 0xDEADBEEF in the low word -> line low word becomes 0xDEADBEEF, other bytes unchanged, dirty=1.
REQ-032 Scenario 3: fill 8 ways of set 2 with tags 0..7 (addresses 0x0000_0040 + k*0x100), dirty one, then access a 9th tag -> victim is the PLRU way; if dirty, pmem_write of the old address precedes pmem_read.
REQ-033 Scenario 4: assert rst=0 during FILL while pmem_read=1 -> pmem_read drops in the same cycle; after release, the same read misses again.
REQ-034 Scenario 5: with L2_PERF_CTR_EN defined, run the sequence miss, hit, hit, write-miss -> hit_count=2, miss_count=2; without the macro both read 0.
REQ-035 Scenario 6: mem_read=mem_write=1 with byte_enable 0 -> treated as a write, mem_resp asserted, dirty unchanged.
